expansion_shiftreg_frame: RTL and testbench

Parametrised successor to the basic shift-register expander. Drives a chain of 74HC595-style outputs and 74HC165-style inputs that share SHIFT_CLK and SHIFT_LOAD. Adds configurable width, clock divider, bit order, load polarity, inter-frame gap, and one-shot or continuous mode. Sits between the RIO register map and board-level expansion chips, and reports frame completion and a frame counter.

---
 rtl/expansion_shiftreg_frame.sv | 194 +++++++++++++++++++
 tb/tb_expansion_shiftreg_frame.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expansion_shiftreg_frame.sv
// Frame engine for a chain of 74HC595-style outputs and 74HC165-style inputs sharing SHIFT_CLK/SHIFT_LOAD.
// Each frame: parallel-load strobe, WIDTH clocked bits out and in, then a one-cycle DONE and optional gap.
module expansion_shiftreg_frame #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIVIDER     = 1,
  parameter bit          CONTINUOUS  = 1'b1,
  parameter int unsigned GAP         = 0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter bit          LOAD_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic             SHIFT_OUT,
  input  logic             SHIFT_IN,
  output logic             SHIFT_CLK,
  output logic             SHIFT_LOAD,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  localparam int unsigned DIV_W = $clog2(DIVIDER + 1);
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);
  localparam int unsigned GAP_W = 16;
  localparam int unsigned CNT_W = 16;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_ACT,
    S_LOAD_REL,
    S_CLK_LO,
    S_CLK_HI,
    S_DONE,
    S_GAP_WAIT
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt, div_cnt_next;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_next;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
  logic [WIDTH-1:0] out_sr, out_sr_next;
  logic [WIDTH-1:0] in_sr, in_sr_next;
  logic [WIDTH-1:0] data_in_next;
  logic [CNT_W-1:0] frame_count_next;
  logic             phase_end;
  logic             load_snap;
  logic             shift_out_next;
  logic             shift_clk_next;
  logic             shift_load_next;
  logic             busy_next;
  logic             frame_done_next;

  // Bit presented on the serial line for a given shift-register value.
  function automatic logic head_bit(input logic [WIDTH-1:0] sr);
    return MSB_FIRST ? sr[WIDTH-1] : sr[0];
  endfunction

  // Next-state, counters, datapath and next-cycle output levels.
  always_comb begin
    state_next       = state;
    div_cnt_next     = '0;
    bit_cnt_next     = bit_cnt;
    gap_cnt_next     = gap_cnt;
    out_sr_next      = out_sr;
    in_sr_next       = in_sr;
    data_in_next     = data_in;
    frame_count_next = frame_count;
    load_snap        = 1'b0;
    phase_end        = (div_cnt == DIV_LAST);

    case (state)
      S_IDLE: begin
        if (CONTINUOUS || start) begin
          state_next = S_LOAD_ACT;
          load_snap  = 1'b1;
        end
      end
      S_LOAD_ACT: begin
        if (phase_end) state_next = S_LOAD_REL;
        else           div_cnt_next = div_cnt + DIV_W'(1);
      end
      S_LOAD_REL: begin
        if (phase_end) begin
          state_next   = S_CLK_LO;
          bit_cnt_next = '0;
        end else begin
          div_cnt_next = div_cnt + DIV_W'(1);
        end
      end
      S_CLK_LO: begin
        if (phase_end) begin
          state_next = S_CLK_HI;
          // Sample on the rising SHIFT_CLK edge; first sampled bit ends at the head end.
          if (MSB_FIRST) in_sr_next = (in_sr << 1) | WIDTH'(SHIFT_IN);
          else           in_sr_next = (in_sr >> 1) | (WIDTH'(SHIFT_IN) << (WIDTH - 1));
        end else begin
          div_cnt_next = div_cnt + DIV_W'(1);
        end
      end
      S_CLK_HI: begin
        if (phase_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_next       = S_DONE;
            data_in_next     = in_sr;
            frame_count_next = frame_count + CNT_W'(1);
          end else begin
            state_next   = S_CLK_LO;
            bit_cnt_next = bit_cnt + BIT_W'(1);
            out_sr_next  = MSB_FIRST ? (out_sr << 1) : (out_sr >> 1);
          end
        end else begin
          div_cnt_next = div_cnt + DIV_W'(1);
        end
      end
      S_DONE: begin
        gap_cnt_next = '0;
        if (GAP > 0) begin
          state_next = S_GAP_WAIT;
        end else if (CONTINUOUS) begin
          state_next = S_LOAD_ACT;
          load_snap  = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_GAP_WAIT: begin
        if (gap_cnt == GAP_LAST) begin
          if (CONTINUOUS) begin
            state_next = S_LOAD_ACT;
            load_snap  = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt + GAP_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (load_snap) out_sr_next = data_out;

    // Outputs are registered from the next state so they line up with the state they belong to.
    shift_load_next = (state_next == S_LOAD_ACT) ? LOAD_ACTIVE : !LOAD_ACTIVE;
    shift_clk_next  = (state_next == S_CLK_HI);
    shift_out_next  = ((state_next == S_CLK_LO) || (state_next == S_CLK_HI)) ?
                      head_bit(out_sr_next) : 1'b0;
    busy_next       = (state_next == S_LOAD_ACT) || (state_next == S_LOAD_REL) ||
                      (state_next == S_CLK_LO)   || (state_next == S_CLK_HI)   ||
                      (state_next == S_DONE);
    frame_done_next = (state_next == S_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      out_sr      <= '0;
      in_sr       <= '0;
      data_in     <= '0;
      frame_count <= '0;
      SHIFT_OUT   <= 1'b0;
      SHIFT_CLK   <= 1'b0;
      SHIFT_LOAD  <= !LOAD_ACTIVE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      div_cnt     <= div_cnt_next;
      bit_cnt     <= bit_cnt_next;
      gap_cnt     <= gap_cnt_next;
      out_sr      <= out_sr_next;
      in_sr       <= in_sr_next;
      data_in     <= data_in_next;
      frame_count <= frame_count_next;
      SHIFT_OUT   <= shift_out_next;
      SHIFT_CLK   <= shift_clk_next;
      SHIFT_LOAD  <= shift_load_next;
      busy        <= busy_next;
      frame_done  <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_expansion_shiftreg_frame.sv
// Bench for expansion_shiftreg_frame: four instances covering bit order, divider, one-shot with gap,
// load polarity and mid-frame reset, checked against queued expectations.
module tb_expansion_shiftreg_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  // Group A: instances a (MSB first) and b (LSB first) share stimulus.
  logic       rst_a_n = 1'b0, start_a = 1'b0, shin_a = 1'b0;
  logic [7:0] data_out_a = 8'h00;
  logic [7:0] din_a, din_b;
  logic       sout_a, sclk_a, sload_a, busy_a, fd_a;
  logic       sout_b, sclk_b, sload_b, busy_b, fd_b;
  logic [15:0] fc_a, fc_b;

  // Group C: WIDTH=16, DIVIDER=3.
  logic        rst_c_n = 1'b0, start_c = 1'b0, shin_c = 1'b1;
  logic [15:0] dout_c = 16'h8001;
  logic [15:0] din_c, fc_c;
  logic        sout_c, sclk_c, sload_c, busy_c, fd_c;

  // Group D: one-shot, GAP=4, active-high load.
  logic       rst_d_n = 1'b0, start_d = 1'b0, shin_d = 1'b1;
  logic [7:0] dout_d = 8'h5A;
  logic [7:0] din_d;
  logic [15:0] fc_d;
  logic       sout_d, sclk_d, sload_d, busy_d, fd_d;

  expansion_shiftreg_frame #(.WIDTH(8), .DIVIDER(1), .CONTINUOUS(1'b1), .GAP(0),
    .MSB_FIRST(1'b1), .LOAD_ACTIVE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .data_out(data_out_a), .data_in(din_a),
    .SHIFT_OUT(sout_a), .SHIFT_IN(shin_a), .SHIFT_CLK(sclk_a), .SHIFT_LOAD(sload_a),
    .busy(busy_a), .frame_done(fd_a), .frame_count(fc_a));

  expansion_shiftreg_frame #(.WIDTH(8), .DIVIDER(1), .CONTINUOUS(1'b1), .GAP(0),
    .MSB_FIRST(1'b0), .LOAD_ACTIVE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .data_out(data_out_a), .data_in(din_b),
    .SHIFT_OUT(sout_b), .SHIFT_IN(shin_a), .SHIFT_CLK(sclk_b), .SHIFT_LOAD(sload_b),
    .busy(busy_b), .frame_done(fd_b), .frame_count(fc_b));

  expansion_shiftreg_frame #(.WIDTH(16), .DIVIDER(3), .CONTINUOUS(1'b1), .GAP(0),
    .MSB_FIRST(1'b1), .LOAD_ACTIVE(1'b0)) u_c (
    .clk(clk), .rst_n(rst_c_n), .start(start_c), .data_out(dout_c), .data_in(din_c),
    .SHIFT_OUT(sout_c), .SHIFT_IN(shin_c), .SHIFT_CLK(sclk_c), .SHIFT_LOAD(sload_c),
    .busy(busy_c), .frame_done(fd_c), .frame_count(fc_c));

  expansion_shiftreg_frame #(.WIDTH(8), .DIVIDER(1), .CONTINUOUS(1'b0), .GAP(4),
    .MSB_FIRST(1'b1), .LOAD_ACTIVE(1'b1)) u_d (
    .clk(clk), .rst_n(rst_d_n), .start(start_d), .data_out(dout_d), .data_in(din_d),
    .SHIFT_OUT(sout_d), .SHIFT_IN(shin_d), .SHIFT_CLK(sclk_d), .SHIFT_LOAD(sload_d),
    .busy(busy_d), .frame_done(fd_d), .frame_count(fc_d));

  // Scoreboard queues.
  logic        q_out_a[$];
  logic        q_out_b[$];
  logic [7:0]  q_din_a[$];
  logic [7:0]  q_din_b[$];
  logic [15:0] q_din_c[$];
  logic [7:0]  q_din_d[$];

  int exp_fc_a = 0;
  int last_done_a = -1;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic probe(input int which);
    case (which)
      0:       return sload_a;
      1:       return sclk_a;
      2:       return fd_a;
      3:       return fd_c;
      default: return busy_d;
    endcase
  endfunction

  // Bounded wait on a selected DUT signal; expiry counts as a failed comparison.
  task automatic wait_for(input int which, input logic level, input string name);
    int k = 0;
    while (probe(which) !== level && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (probe(which) !== level) begin
      n_total++;
      $display("FAIL timeout %s: signal stayed %b, required %b", name, probe(which), level);
    end
  endtask

  // One group-A frame: serial input pattern (first bit = bits[7]) and expected SHIFT_OUT word.
  task automatic drive_frame_a(input logic [7:0] bits, input logic [7:0] exp_out,
                               input logic [7:0] change_to, input string tag);
    logic       eo;
    logic [7:0] ed;
    for (int i = 0; i < 8; i++) begin
      q_out_a.push_back(exp_out[7-i]);
      q_out_b.push_back(exp_out[i]);
    end
    q_din_a.push_back(bits);
    q_din_b.push_back(rev8(bits));
    wait_for(0, 1'b0, "load_act_a");
    wait_for(0, 1'b1, "load_rel_a");
    data_out_a = change_to;
    for (int i = 0; i < 8; i++) begin
      shin_a = bits[7-i];
      wait_for(1, 1'b1, "clk_hi_a");
      eo = q_out_a.pop_front();
      n_total++;
      if (sout_a !== eo) $display("FAIL %s sout_a bit %0d: got %b required %b", tag, i, sout_a, eo);
      else n_pass++;
      eo = q_out_b.pop_front();
      n_total++;
      if (sout_b !== eo) $display("FAIL %s sout_b bit %0d: got %b required %b", tag, i, sout_b, eo);
      else n_pass++;
      wait_for(1, 1'b0, "clk_lo_a");
    end
    wait_for(2, 1'b1, "done_a");
    exp_fc_a++;
    ed = q_din_a.pop_front();
    n_total++;
    if (din_a !== ed) $display("FAIL %s data_in_a: got %h required %h", tag, din_a, ed);
    else n_pass++;
    ed = q_din_b.pop_front();
    n_total++;
    if (din_b !== ed) $display("FAIL %s data_in_b: got %h required %h", tag, din_b, ed);
    else n_pass++;
    n_total++;
    if (fc_a !== 16'(exp_fc_a) || fc_b !== 16'(exp_fc_a))
      $display("FAIL %s frame_count: got %0d/%0d required %0d", tag, fc_a, fc_b, exp_fc_a);
    else n_pass++;
    if (last_done_a >= 0) begin
      n_total++;
      if (cyc - last_done_a != 19)
        $display("FAIL %s frame period: got %0d required 19", tag, cyc - last_done_a);
      else n_pass++;
    end
    last_done_a = cyc;
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; rst_c_n = 1'b0; rst_d_n = 1'b0;
    data_out_a = 8'h03;
    repeat (3) @(negedge clk);
    n_total++;
    if ({sclk_a, sout_a, sload_a, busy_a, fd_a} !== 5'b00100)
      $display("FAIL reset a outputs: got %b required 00100", {sclk_a, sout_a, sload_a, busy_a, fd_a});
    else n_pass++;
    n_total++;
    if ({sclk_b, sout_b, sload_b, busy_b, fd_b} !== 5'b00100)
      $display("FAIL reset b outputs: got %b required 00100", {sclk_b, sout_b, sload_b, busy_b, fd_b});
    else n_pass++;
    n_total++;
    if ({sclk_c, sout_c, sload_c, busy_c, fd_c} !== 5'b00100)
      $display("FAIL reset c outputs: got %b required 00100", {sclk_c, sout_c, sload_c, busy_c, fd_c});
    else n_pass++;
    n_total++;
    if ({sclk_d, sout_d, sload_d, busy_d, fd_d} !== 5'b00000)
      $display("FAIL reset d outputs: got %b required 00000", {sclk_d, sout_d, sload_d, busy_d, fd_d});
    else n_pass++;
    n_total++;
    if ({din_a, din_b, din_c, din_d} !== 40'h0)
      $display("FAIL reset data_in: got %h required 0", {din_a, din_b, din_c, din_d});
    else n_pass++;
    n_total++;
    if ({fc_a, fc_b, fc_c, fc_d} !== 64'h0)
      $display("FAIL reset frame_count: got %h required 0", {fc_a, fc_b, fc_c, fc_d});
    else n_pass++;
    rst_a_n = 1'b1; rst_c_n = 1'b1; rst_d_n = 1'b1;
  endtask

  task automatic test_shift_frames();
    logic [7:0] r;
    drive_frame_a(8'hA5, 8'h03, 8'h03, "pat_a5");
    drive_frame_a(8'hC0, 8'h03, 8'h3C, "pat_c0_change");
    r = 8'($urandom);
    drive_frame_a(r, 8'h3C, 8'h3C, "new_data");
    r = 8'($urandom);
    drive_frame_a(r, 8'h3C, 8'h3C, "random");
    drive_frame_a(8'h96, 8'h3C, 8'h3C, "pat_96");
  endtask

  task automatic test_midframe_reset();
    wait_for(0, 1'b0, "load_act_a");
    wait_for(0, 1'b1, "load_rel_a");
    for (int i = 0; i < 4; i++) begin
      wait_for(1, 1'b1, "clk_hi_a");
      wait_for(1, 1'b0, "clk_lo_a");
    end
    wait_for(1, 1'b1, "clk_hi_a bit4");
    rst_a_n = 1'b0;
    @(negedge clk);
    n_total++;
    if ({sclk_a, sout_a, sload_a, busy_a, fd_a, sclk_b, sload_b, busy_b} !== 8'b00100_010)
      $display("FAIL midframe reset outputs: got %b required 00100010",
               {sclk_a, sout_a, sload_a, busy_a, fd_a, sclk_b, sload_b, busy_b});
    else n_pass++;
    n_total++;
    if ({din_a, din_b} !== 16'h0) $display("FAIL midframe reset data_in: got %h required 0", {din_a, din_b});
    else n_pass++;
    n_total++;
    if ({fc_a, fc_b} !== 32'h0) $display("FAIL midframe reset frame_count: got %h required 0", {fc_a, fc_b});
    else n_pass++;
    rst_a_n = 1'b1;
    exp_fc_a = 0;
    last_done_a = -1;
    drive_frame_a(8'h81, 8'h3C, 8'h3C, "after_reset");
  endtask

  task automatic test_divider();
    logic [15:0] ed;
    logic [15:0] fc0;
    int n = 0, load_low = 0, hi_runs = 0, bad = 0, run = 0;
    logic prev = 1'b0, seen_hi = 1'b0;
    q_din_c.push_back(16'hFFFF);
    wait_for(3, 1'b1, "done_c");
    ed = q_din_c.pop_front();
    n_total++;
    if (din_c !== ed) $display("FAIL div data_in_c: got %h required %h", din_c, ed);
    else n_pass++;
    fc0 = fc_c;
    prev = sclk_c;
    do begin
      @(negedge clk);
      n++;
      if (sload_c == 1'b0) load_low++;
      if (sclk_c != prev) begin
        if (prev) begin
          hi_runs++;
          if (run != 3) bad++;
          seen_hi = 1'b1;
        end else if (seen_hi && run != 3) begin
          bad++;
        end
        run = 1;
      end else begin
        run++;
      end
      prev = sclk_c;
    end while (!fd_c && n < 300);
    n_total++;
    if (n != 103) $display("FAIL div frame length: got %0d required 103", n);
    else n_pass++;
    n_total++;
    if (load_low != 3) $display("FAIL div load low cycles: got %0d required 3", load_low);
    else n_pass++;
    n_total++;
    if (hi_runs != 16) $display("FAIL div clock pulses: got %0d required 16", hi_runs);
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL div half-period: got %0d runs not 3 cycles, required 0", bad);
    else n_pass++;
    n_total++;
    if (fc_c !== fc0 + 16'd1) $display("FAIL div frame_count step: got %0d required %0d", fc_c, fc0 + 16'd1);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [7:0] ed;
    int viol = 0, n = 0, lac = 0, fdc = 0, low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy_d || sload_d || sclk_d || fc_d != 16'd0) viol++;
    end
    n_total++;
    if (viol != 0) $display("FAIL oneshot idle activity: got %0d active cycles required 0", viol);
    else n_pass++;

    shin_d = 1'b1;
    q_din_d.push_back(8'hFF);
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    n_total++;
    if (busy_d !== 1'b1) $display("FAIL oneshot start latency: busy got %b required 1", busy_d);
    else n_pass++;
    while (busy_d && n < 100) begin
      n++;
      if (sload_d) lac++;
      if (fd_d) begin
        fdc++;
        ed = q_din_d.pop_front();
        n_total++;
        if (din_d !== ed) $display("FAIL oneshot data_in: got %h required %h", din_d, ed);
        else n_pass++;
        n_total++;
        if (fc_d !== 16'd1) $display("FAIL oneshot frame_count: got %0d required 1", fc_d);
        else n_pass++;
      end
      start_d = (n == 5);
      @(negedge clk);
    end
    start_d = 1'b0;
    n_total++;
    if (n != 19) $display("FAIL oneshot busy length: got %0d required 19", n);
    else n_pass++;
    n_total++;
    if (lac != 1 || fdc != 1)
      $display("FAIL oneshot load/done pulses: got %0d/%0d required 1/1", lac, fdc);
    else n_pass++;

    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_d || fc_d != 16'd1) viol++;
    end
    n_total++;
    if (viol != 0) $display("FAIL oneshot extra frame: got %0d busy cycles required 0", viol);
    else n_pass++;

    shin_d = 1'b0;
    q_din_d.push_back(8'h00);
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    n = 0;
    while (busy_d && n < 100) begin
      n++;
      if (fd_d) begin
        ed = q_din_d.pop_front();
        n_total++;
        if (din_d !== ed || fc_d !== 16'd2)
          $display("FAIL oneshot second frame: got %h/%0d required %h/2", din_d, fc_d, ed);
        else n_pass++;
      end
      @(negedge clk);
    end
    start_d = 1'b1;
    while (!busy_d && low < 50) begin
      low++;
      @(negedge clk);
    end
    start_d = 1'b0;
    n_total++;
    if (low != 5) $display("FAIL oneshot gap: got %0d idle cycles required 5", low);
    else n_pass++;
    wait_for(4, 1'b0, "busy_d fall");
    n_total++;
    if (fc_d !== 16'd3) $display("FAIL oneshot final count: got %0d required 3", fc_d);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_shift_frames();
    test_midframe_reset();
    test_divider();
    test_oneshot();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
